// File: rtl/amp_spi_pkg.sv
// Shared constants, state encoding and frame builder for the amplitude
// readback SPI transmitter.
package amp_spi_pkg;

    localparam int FRAME_W   = 32;
    localparam int RANGE_MAX = 7;

    // Status field positions inside the 32-bit frame
    localparam int ST_FRESH  = 31;
    localparam int ST_OOR    = 30;
    localparam int ST_SEQ_HI = 27;
    localparam int ST_SEQ_LO = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    // Assemble {fresh, oor, 2'b00, seq, amp_dat, a_ver}
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic        fresh,
        input logic        oor,
        input logic [3:0]  seq,
        input logic [23:0] data
    );
        logic [FRAME_W-1:0] f;
        f                       = '0;
        f[ST_FRESH]             = fresh;
        f[ST_OOR]               = oor;
        f[ST_SEQ_HI:ST_SEQ_LO]  = seq;
        f[23:0]                 = data;
        return f;
    endfunction

endpackage

// File: rtl/amp_ver_spi_tx_if.sv
// Bus bundle between the STM32-facing pins / amplitude path and the
// readback transmitter.
interface amp_ver_spi_tx_if;
    logic [15:0] amp_dat;
    logic [7:0]  a_ver;
    logic        dat_valid;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_miso;
    logic        miso_oe;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_abort;

    // Driver side: data source plus SPI master pins
    modport master (
        output amp_dat, a_ver, dat_valid, spi_cs_n, spi_sclk,
        input  spi_miso, miso_oe, tx_busy, tx_done, tx_abort
    );

    // Transmitter side
    modport slave (
        input  amp_dat, a_ver, dat_valid, spi_cs_n, spi_sclk,
        output spi_miso, miso_oe, tx_busy, tx_done, tx_abort
    );
endinterface

// File: rtl/amp_ver_spi_tx_sync.sv
// Multi-flop synchroniser for an asynchronous SPI pin with rise/fall
// pulse generation in the clk domain. SYNC_STAGES must be at least 2.
module spi_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   last_q;

    // Shift the pin through the synchroniser and keep one cycle of history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= {SYNC_STAGES{RST_VAL}};
            last_q    <= RST_VAL;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
            last_q    <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign rise =  sync_pipe[SYNC_STAGES-1] & ~last_q;
    assign fall = ~sync_pipe[SYNC_STAGES-1] &  last_q;

endmodule

// File: rtl/amp_ver_spi_tx.sv
// SPI-slave readback transmitter: returns a 32-bit status/amplitude
// snapshot to the STM32 in SPI mode 0, MSB first.
module amp_ver_spi_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_W     = amp_spi_pkg::FRAME_W,
    parameter int RANGE_MAX   = amp_spi_pkg::RANGE_MAX
) (
    input logic            clk,
    input logic            rst,
    amp_ver_spi_tx_if.slave bus
);
    import amp_spi_pkg::*;

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    tx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [23:0]        shadow_q;
    logic               fresh_q, oor_q, upd_pend_q;
    logic [3:0]         seq_q;
    logic               miso_oe_q, tx_busy_q, tx_done_q, tx_abort_q;
    logic               start_evt, done_evt, abort_evt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and single-cycle event strobes; abort beats everything
    always_comb begin
        state_d   = state_q;
        start_evt = 1'b0;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = LOAD;
                    start_evt = 1'b1;
                end
            end
            LOAD: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    abort_evt = 1'b1;
                end else begin
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    abort_evt = 1'b1;
                end else if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                    state_d  = DONE;
                    done_evt = 1'b1;
                end
            end
            DONE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame shifter and pad control; zeros shift in so overclocked bits read 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            miso_oe_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
        end else begin
            tx_done_q  <= done_evt;
            tx_abort_q <= abort_evt;
            if (abort_evt) begin
                shreg_q   <= '0;
                miso_oe_q <= 1'b0;
                tx_busy_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        shreg_q   <= '0;
                        miso_oe_q <= 1'b0;
                        tx_busy_q <= 1'b0;
                    end
                    LOAD: begin
                        shreg_q   <= FRAME_W'(build_frame(fresh_q, oor_q, seq_q, shadow_q));
                        bit_cnt_q <= '0;
                        miso_oe_q <= 1'b1;
                        tx_busy_q <= 1'b1;
                    end
                    SHIFT: begin
                        if (sclk_rise) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (sclk_fall) shreg_q   <= {shreg_q[FRAME_W-2:0], 1'b0};
                    end
                    DONE: begin
                        if (cs_rise) begin
                            shreg_q   <= '0;
                            miso_oe_q <= 1'b0;
                            tx_busy_q <= 1'b0;
                        end else if (sclk_fall) begin
                            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                    default: shreg_q <= '0;
                endcase
            end
        end
    end

    // Shadow snapshot and status; fresh survives a completed frame when
    // newer data arrived after that frame was loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            fresh_q    <= 1'b0;
            oor_q      <= 1'b0;
            seq_q      <= '0;
            upd_pend_q <= 1'b0;
        end else begin
            if (bus.dat_valid) begin
                shadow_q <= {bus.amp_dat, bus.a_ver};
                fresh_q  <= 1'b1;
                oor_q    <= (bus.amp_dat[15:8] > 8'(RANGE_MAX));
            end else if (done_evt) begin
                fresh_q  <= upd_pend_q;
            end
            if (done_evt) seq_q <= seq_q + 4'd1;
            if (start_evt)
                upd_pend_q <= 1'b0;
            else if (bus.dat_valid && state_q != IDLE)
                upd_pend_q <= 1'b1;
        end
    end

    assign bus.spi_miso = shreg_q[FRAME_W-1];
    assign bus.miso_oe  = miso_oe_q;
    assign bus.tx_busy  = tx_busy_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_abort = tx_abort_q;

endmodule

// File: tb/tb_amp_ver_spi_tx.sv
// Directed bench: acts as the STM32 SPI master in mode 0 and checks the
// captured frames and handshake pulses against hand-computed values.
module tb_amp_ver_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    amp_ver_spi_tx_if bus();

    amp_ver_spi_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_valid(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.amp_dat   = a;
        bus.a_ver     = v;
        bus.dat_valid = 1'b1;
        @(negedge clk);
        bus.dat_valid = 1'b0;
    endtask

    // Mode-0 master: sample MISO just before each SCLK rise; optionally
    // pulse dat_valid after bit upd_at; leaves CS_N low
    task automatic spi_read(input int nbits, input int upd_at,
                            input logic [15:0] ua, input logic [7:0] uv,
                            output logic [63:0] rx);
        rx = '0;
        bus.spi_cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            rx = {rx[62:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            #50;
            bus.spi_sclk = 1'b0;
            if (i == upd_at) pulse_valid(ua, uv);
            #50;
        end
        #100;
    endtask

    task automatic cs_release();
        bus.spi_cs_n = 1'b1;
        #100;
    endtask

    logic [63:0] rx;
    int d0, a0;

    initial begin
        bus.amp_dat   = '0;
        bus.a_ver     = '0;
        bus.dat_valid = 1'b0;
        bus.spi_cs_n  = 1'b1;
        bus.spi_sclk  = 1'b0;
        #23;
        rst = 1'b0;
        #20;
        check("rst_miso",  bus.spi_miso, 0);
        check("rst_oe",    bus.miso_oe,  0);
        check("rst_busy",  bus.tx_busy,  0);
        check("rst_done",  bus.tx_done,  0);
        check("rst_abort", bus.tx_abort, 0);

        // 1: fresh snapshot, seq 0
        pulse_valid(16'h0312, 8'h07);
        d0 = done_cnt;
        spi_read(32, -1, 16'h0, 8'h0, rx);
        check("t1_busy_in_done", bus.tx_busy, 1);
        check("t1_oe_in_done",   bus.miso_oe, 1);
        check("t1_frame", rx[31:0], 32'h80031207);
        check("t1_done_cnt", done_cnt - d0, 1);
        cs_release();
        check("t1_oe_after", bus.miso_oe, 0);
        check("t1_busy_after", bus.tx_busy, 0);

        // 2: repeat read, stale data, seq 1
        d0 = done_cnt;
        spi_read(32, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t2_frame", rx[31:0], 32'h01031207);
        check("t2_done_cnt", done_cnt - d0, 1);

        // 3: range index 10 sets oor, seq 2
        pulse_valid(16'h0A00, 8'h5A);
        spi_read(32, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t3_frame", rx[31:0], 32'hC20A005A);

        // 4: abort after 12 SCLK cycles keeps seq 3 and fresh
        pulse_valid(16'h0155, 8'h33);
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_read(12, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t4_partial", rx[11:0], 12'h830);
        check("t4_abort_cnt", abort_cnt - a0, 1);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_oe_after", bus.miso_oe, 0);
        check("t4_busy_after", bus.tx_busy, 0);
        spi_read(32, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t4_reread", rx[31:0], 32'h83015533);

        // 5: update mid-frame does not disturb the frame in flight
        spi_read(32, 10, 16'hFFFF, 8'hEE, rx);
        cs_release();
        check("t5_current", rx[31:0], 32'h04015533);
        spi_read(32, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t5_next", rx[31:0], 32'hC5FFFFEE);

        // 6: 40 SCLK cycles, overclocked bits read 0, one tx_done
        d0 = done_cnt;
        spi_read(40, -1, 16'h0, 8'h0, rx);
        check("t6_frame40", rx[39:0], {32'h46FFFFEE, 8'h00});
        check("t6_done_cnt", done_cnt - d0, 1);
        cs_release();

        // 6b: reset mid-SHIFT releases the pad and clears seq immediately
        bus.spi_cs_n = 1'b0;
        #100;
        for (int i = 0; i < 5; i++) begin
            bus.spi_sclk = 1'b1;
            #50;
            bus.spi_sclk = 1'b0;
            #50;
        end
        check("t6_oe_before_rst", bus.miso_oe, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_oe",   bus.miso_oe,  0);
        check("t6_rst_busy", bus.tx_busy,  0);
        check("t6_rst_miso", bus.spi_miso, 0);
        check("t6_rst_seq",  dut.seq_q,    0);
        bus.spi_cs_n = 1'b1;
        #50;
        rst = 1'b0;
        #100;
        check("t6_oe_released", bus.miso_oe, 0);
        pulse_valid(16'h0312, 8'h07);
        spi_read(32, -1, 16'h0, 8'h0, rx);
        cs_release();
        check("t6_post_rst_frame", rx[31:0], 32'h80031207);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
